// File: rtl/reg_cfg_writer.sv
// reg_cfg_writer: host-side initiator for the 8-bit addr/data/update register
// write interface. Accepts one waveform configuration, splits it into six byte
// registers, and issues one timed write cycle (setup / pulse / hold) for each
// byte that differs from the shadow copy of the register core contents.
module reg_cfg_writer #(
  parameter int SETUP_CYC = 2,  // addr/data stable with update=0 before update rises (1..255)
  parameter int PULSE_CYC = 2,  // update high time (1..255)
  parameter int HOLD_CYC  = 2   // addr/data held with update=0 after update falls (1..255)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] inc_phi,
  input  logic [3:0]  occupation,
  input  logic [3:0]  waveform,
  input  logic [3:0]  bit_gain,
  input  logic        force_all,
  output logic [7:0]  addr,
  output logic [7:0]  data,
  output logic        update,
  output logic        busy,
  output logic        done
);

  localparam int NREG = 6;

  // Phase counters load PARAM-1 and count down to zero, so a phase lasts PARAM cycles.
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_DONE
  } state_t;

  // Register core contents after its own reset; the shadow must start from the same values.
  function automatic logic [7:0] shadow_default(input int idx);
    case (idx)
      0:       shadow_default = 8'd242;
      3:       shadow_default = 8'd82;
      default: shadow_default = 8'd0;
    endcase
  endfunction

  state_t                     r_state;
  logic                       r_ready;
  logic                       r_update;
  logic                       r_done;
  logic [7:0]                 r_addr;
  logic [7:0]                 r_data;
  logic [7:0]                 r_cnt;
  logic [2:0]                 r_idx;
  logic [NREG-1:0]            r_mask;
  logic [NREG-1:0][7:0]       r_byte;
  logic [NREG-1:0][7:0]       r_shadow;

  logic [NREG-1:0][7:0]       w_new_byte;
  logic [NREG-1:0]            w_dirty;
  logic                       w_accept;
  logic                       w_sel_found;
  logic [2:0]                 w_sel_idx;

  // Byte map of the incoming configuration.
  assign w_new_byte[0] = {occupation, waveform};
  assign w_new_byte[1] = inc_phi[7:0];
  assign w_new_byte[2] = inc_phi[15:8];
  assign w_new_byte[3] = inc_phi[23:16];
  assign w_new_byte[4] = inc_phi[31:24];
  assign w_new_byte[5] = {4'b0000, bit_gain};

  // A register needs a write if forced or if it differs from what the core holds.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_dirty
      assign w_dirty[gi] = force_all || (w_new_byte[gi] != r_shadow[gi]);
    end
  endgenerate

  assign w_accept = cfg_valid && r_ready;

  // Pick the lowest pending register so writes go out in ascending address order.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = 3'd0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (r_mask[i]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = 3'(i);
      end
    end
  end

  // Write sequencer: all outputs are registered so the bus sees clean, glitch-free edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b1;
      r_update <= 1'b0;
      r_done   <= 1'b0;
      r_addr   <= 8'd0;
      r_data   <= 8'd0;
      r_cnt    <= 8'd0;
      r_idx    <= 3'd0;
      r_mask   <= '0;
      for (int i = 0; i < NREG; i++) begin
        r_byte[i]   <= 8'd0;
        r_shadow[i] <= shadow_default(i);
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_byte  <= w_new_byte;
            r_mask  <= w_dirty;
            r_ready <= 1'b0;
            r_state <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (w_sel_found) begin
            r_idx   <= w_sel_idx;
            r_addr  <= {5'b00000, w_sel_idx};
            r_data  <= r_byte[w_sel_idx];
            r_cnt   <= SETUP_LD;
            r_state <= S_SETUP;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_SETUP: begin
          if (r_cnt == 8'd0) begin
            r_update <= 1'b1;
            r_cnt    <= PULSE_LD;
            r_state  <= S_PULSE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        S_PULSE: begin
          if (r_cnt == 8'd0) begin
            r_update <= 1'b0;
            r_cnt    <= HOLD_LD;
            r_state  <= S_HOLD;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        S_HOLD: begin
          // The core has latched the byte by now, so the shadow can follow.
          if (r_cnt == 8'd0) begin
            r_mask[r_idx]   <= 1'b0;
            r_shadow[r_idx] <= r_byte[r_idx];
            r_state         <= S_SCAN;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        S_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_update <= 1'b0;
          r_ready  <= 1'b1;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign cfg_ready = r_ready;
  assign busy      = !r_ready;
  assign addr      = r_addr;
  assign data      = r_data;
  assign update    = r_update;
  assign done      = r_done;

endmodule

// File: tb/tb_reg_cfg_writer.sv
// Testbench for reg_cfg_writer: table vectors, hand sequences for reset and
// held-valid corner cases, and randomized configurations against a model
// that predicts the write list and cycle timing from the interface rules.
`timescale 1ns/1ps
module tb_reg_cfg_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [31:0] inc_phi = '0;
  logic [3:0]  occupation = '0;
  logic [3:0]  waveform = '0;
  logic [3:0]  bit_gain = '0;
  logic        force_all = 1'b0;

  logic        a_ready, a_update, a_busy, a_done;
  logic [7:0]  a_addr, a_data;
  logic        b_ready, b_update, b_busy, b_done;
  logic [7:0]  b_addr, b_data;

  logic        use2 = 1'b0;
  logic        m_ready, m_update, m_busy, m_done;
  logic [7:0]  m_addr, m_data;

  always #5 clk = ~clk;

  reg_cfg_writer dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(a_ready),
    .inc_phi(inc_phi), .occupation(occupation), .waveform(waveform),
    .bit_gain(bit_gain), .force_all(force_all), .addr(a_addr), .data(a_data),
    .update(a_update), .busy(a_busy), .done(a_done)
  );

  reg_cfg_writer #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(1)) dut2 (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(b_ready),
    .inc_phi(inc_phi), .occupation(occupation), .waveform(waveform),
    .bit_gain(bit_gain), .force_all(force_all), .addr(b_addr), .data(b_data),
    .update(b_update), .busy(b_busy), .done(b_done)
  );

  assign m_ready  = use2 ? b_ready  : a_ready;
  assign m_update = use2 ? b_update : a_update;
  assign m_busy   = use2 ? b_busy   : a_busy;
  assign m_done   = use2 ? b_done   : a_done;
  assign m_addr   = use2 ? b_addr   : a_addr;
  assign m_data   = use2 ? b_data   : a_data;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: what the register core holds, and the last bus values.
  logic [7:0] m_shadow [6];
  logic [7:0] m_last_addr, m_last_data;

  function automatic void model_reset();
    m_shadow[0] = 8'd242; m_shadow[1] = 8'd0; m_shadow[2] = 8'd0;
    m_shadow[3] = 8'd82;  m_shadow[4] = 8'd0; m_shadow[5] = 8'd0;
    m_last_addr = 8'd0;
    m_last_data = 8'd0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Called just after the accept edge; checks every cycle up to the IDLE cycle after done.
  task automatic check_txn(input logic [31:0] inc, input logic [3:0] occ, input logic [3:0] wav,
                           input logic [3:0] gain, input logic frc,
                           input int S, input int P, input int H,
                           output logic [5:0] obs_mask, output int obs_done);
    logic [7:0] b [6];
    int wa[$];
    int W, n, c, j, off;
    logic [7:0] ea, ed;
    logic eu, prev_upd;
    logic [5:0] exp_mask;
    W = 1 + S + P + H;
    b[0] = {occ, wav};
    b[1] = inc[7:0]; b[2] = inc[15:8]; b[3] = inc[23:16]; b[4] = inc[31:24];
    b[5] = {4'h0, gain};
    exp_mask = '0;
    for (int i = 0; i < 6; i++) begin
      if (frc || b[i] != m_shadow[i]) begin
        wa.push_back(i);
        exp_mask[i] = 1'b1;
      end
    end
    n = wa.size();
    obs_mask = '0;
    obs_done = -1;
    prev_upd = 1'b0;
    for (int k = 1; k <= W * n + 3; k++) begin
      @(negedge clk);
      ea = m_last_addr; ed = m_last_data; eu = 1'b0;
      c = (k - 1) / W;
      if (c > 0) begin ea = 8'(wa[c-1]); ed = b[wa[c-1]]; end
      if (k >= 2) begin
        j = (k - 2) / W; off = (k - 2) % W;
        if (j < n && off < S + P + H) begin
          ea = 8'(wa[j]); ed = b[wa[j]];
          eu = (off >= S) && (off < S + P);
        end
      end
      chk($sformatf("update k=%0d", k), m_update, eu);
      chk($sformatf("addr k=%0d", k), m_addr, ea);
      chk($sformatf("data k=%0d", k), m_data, ed);
      chk($sformatf("done k=%0d", k), m_done, (k == W * n + 2));
      chk($sformatf("ready k=%0d", k), m_ready, (k == W * n + 3));
      chk($sformatf("busy k=%0d", k), m_busy, (k != W * n + 3));
      if (m_update && !prev_upd && m_addr < 8'd6) obs_mask[m_addr[2:0]] = 1'b1;
      if (m_done === 1'b1) obs_done = k;
      prev_upd = m_update;
    end
    chk("write_set", obs_mask, exp_mask);
    chk("done_cycle", obs_done, W * n + 2);
    foreach (wa[i]) m_shadow[wa[i]] = b[wa[i]];
    if (n > 0) begin m_last_addr = 8'(wa[n-1]); m_last_data = b[wa[n-1]]; end
  endtask

  task automatic run_cfg(input logic [31:0] inc, input logic [3:0] occ, input logic [3:0] wav,
                         input logic [3:0] gain, input logic frc,
                         input int S, input int P, input int H,
                         output logic [5:0] obs_mask, output int obs_done);
    inc_phi = inc; occupation = occ; waveform = wav; bit_gain = gain; force_all = frc;
    cfg_valid = 1'b1;
    chk("ready_before_accept", m_ready, 1'b1);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    check_txn(inc, occ, wav, gain, frc, S, P, H, obs_mask, obs_done);
    $display("txn inc=%08h occ=%0h wav=%0h gain=%0h force=%0b writes=%06b done@%0d",
             inc, occ, wav, gain, frc, obs_mask, obs_done);
  endtask

  typedef struct {
    logic [31:0] inc;
    logic [3:0]  occ;
    logic [3:0]  wav;
    logic [3:0]  gain;
    logic        frc;
    logic [5:0]  exp_mask;
    int          exp_done;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  om;
    int          od;
    logic [31:0] r_inc;
    logic [3:0]  r_occ, r_wav, r_gain;
    logic        r_frc;

    tbl[0] = '{32'h00520000, 4'hF, 4'h2, 4'h0, 1'b0, 6'b000000, 2};
    tbl[1] = '{32'h12345678, 4'hF, 4'h2, 4'h0, 1'b0, 6'b011110, 30};
    tbl[2] = '{32'h12345678, 4'hF, 4'h2, 4'h0, 1'b0, 6'b000000, 2};
    tbl[3] = '{32'h12345678, 4'hF, 4'h2, 4'h0, 1'b1, 6'b111111, 44};
    tbl[4] = '{32'h12345678, 4'hF, 4'h2, 4'hA, 1'b0, 6'b100000, 9};
    tbl[5] = '{32'h12345600, 4'h3, 4'h1, 4'hA, 1'b0, 6'b000011, 16};

    do_reset();
    chk("rst_addr", a_addr, 8'd0);
    chk("rst_data", a_data, 8'd0);
    chk("rst_update", a_update, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_ready", a_ready, 1'b1);
    chk("rst_busy", a_busy, 1'b0);

    // Table vectors, defaults timing.
    for (int i = 0; i < 6; i++) begin
      run_cfg(tbl[i].inc, tbl[i].occ, tbl[i].wav, tbl[i].gain, tbl[i].frc, 2, 2, 2, om, od);
      chk($sformatf("tbl%0d_mask", i), om, tbl[i].exp_mask);
      chk($sformatf("tbl%0d_done", i), od, tbl[i].exp_done);
    end

    // Non-default timing: single gain write with SETUP=3, PULSE=1, HOLD=1.
    do_reset();
    use2 = 1'b1;
    run_cfg(32'h00520000, 4'hF, 4'h2, 4'hA, 1'b0, 3, 1, 1, om, od);
    chk("t2_mask", om, 6'b100000);
    chk("t2_done", od, 8);
    use2 = 1'b0;

    // Reset during PULSE of the second write, then resend.
    do_reset();
    inc_phi = 32'h12345678; occupation = 4'hF; waveform = 4'h2; bit_gain = 4'h0; force_all = 1'b0;
    cfg_valid = 1'b1;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    repeat (11) @(negedge clk);
    chk("mid_pulse_update", a_update, 1'b1);
    chk("mid_pulse_addr", a_addr, 8'd2);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_update", a_update, 1'b0);
    chk("mid_rst_done", a_done, 1'b0);
    chk("mid_rst_ready", a_ready, 1'b1);
    chk("mid_rst_addr", a_addr, 8'd0);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk("after_rst_done", a_done, 1'b0);
    $display("txn reset during second write pulse");
    run_cfg(32'h12345678, 4'hF, 4'h2, 4'h0, 1'b0, 2, 2, 2, om, od);
    chk("resend_mask", om, 6'b011110);

    // cfg_valid held high across two configs.
    do_reset();
    inc_phi = 32'h00520011; occupation = 4'hF; waveform = 4'h2; bit_gain = 4'h0; force_all = 1'b0;
    cfg_valid = 1'b1;
    chk("held_ready_a", a_ready, 1'b1);
    @(posedge clk);
    #1 inc_phi = 32'h00520000; bit_gain = 4'h3;
    check_txn(32'h00520011, 4'hF, 4'h2, 4'h0, 1'b0, 2, 2, 2, om, od);
    chk("held_a_mask", om, 6'b000010);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    check_txn(32'h00520000, 4'hF, 4'h2, 4'h3, 1'b0, 2, 2, 2, om, od);
    chk("held_b_mask", om, 6'b100010);
    $display("txn held valid: second config accepted after IDLE cycle");

    // Randomized configurations by mutating the previous one.
    r_inc = 32'h00520000; r_occ = 4'hF; r_wav = 4'h2; r_gain = 4'h0;
    for (int it = 0; it < 25; it++) begin
      for (int bi = 0; bi < 4; bi++)
        if ($urandom_range(2) == 0) r_inc[bi*8 +: 8] = 8'($urandom);
      if ($urandom_range(2) == 0) r_occ = 4'($urandom);
      if ($urandom_range(2) == 0) r_wav = 4'($urandom);
      if ($urandom_range(2) == 0) r_gain = 4'($urandom);
      r_frc = ($urandom_range(4) == 0);
      run_cfg(r_inc, r_occ, r_wav, r_gain, r_frc, 2, 2, 2, om, od);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
